// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: datapath widths, load funct3
// encodings, FSM state encoding and the captured load context.
package writeback_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned XADDR = 5;

    // Load size/sign encodings (funct3 field)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

    // Fields of an accepted load needed to finish it once the response arrives
    typedef struct packed {
        logic       rd_we;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } load_ctx_t;

endpackage

// File: rtl/writeback_stage_load_aligner.sv
// Load aligner: extracts and sign/zero-extends the addressed byte/halfword/word
// from a data-memory read word, and flags illegal or misaligned loads.
// Ports:
//   funct3_i   load size/sign encoding
//   addr_lo_i  byte offset within the word
//   rdata_i    data-memory read word
//   data_o     aligned, extended load data
//   illegal_o  load encoding invalid or misaligned
module writeback_stage_load_aligner
    import writeback_stage_pkg::*;
#(
    parameter int unsigned DW = XLEN
) (
    input  logic [2:0]    funct3_i,
    input  logic [1:0]    addr_lo_i,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] data_o,
    output logic          illegal_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword lane is chosen by addr_lo[1]; addr_lo[0] only matters for legality
    assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(DW-8){byte_v[7]}}, byte_v};
            F3_LBU: data_o = {{(DW-8){1'b0}}, byte_v};
            F3_LH: begin
                data_o    = {{(DW-16){half_v[15]}}, half_v};
                illegal_o = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o    = {{(DW-16){1'b0}}, half_v};
                illegal_o = addr_lo_i[0];
            end
            F3_LW: begin
                data_o    = rdata_i;
                illegal_o = (addr_lo_i != 2'b00);
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: final pipeline stage driving the register file write port.
// Non-loads retire the cycle after accept; legal loads wait for the data-memory
// response (bounded by TIMEOUT), then write aligned data. Illegal loads and
// timeouts produce a single-cycle load-fault pulse instead.
// Ports:
//   i_clk, i_rst             clock, async active-high reset
//   i_valid / o_ready        upstream handshake (ready only in IDLE)
//   i_rd_we, i_rd_addr       destination register write request
//   i_result                 non-load result
//   i_is_load, i_funct3,
//   i_addr_lo                load descriptor
//   i_dmem_rvalid/rdata      data-memory read response
//   or_wr_en/rd_addr/rd_data register file write port (registered)
//   or_retire                pulse per completed instruction
//   or_load_fault            pulse per illegal or timed-out load
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned XLEN    = writeback_stage_pkg::XLEN,
    parameter int unsigned XADDR   = writeback_stage_pkg::XADDR,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_rd_we,
    input  logic [XADDR-1:0] i_rd_addr,
    input  logic [XLEN-1:0]  i_result,
    input  logic             i_is_load,
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_addr_lo,
    input  logic             i_dmem_rvalid,
    input  logic [XLEN-1:0]  i_dmem_rdata,
    output logic             or_wr_en,
    output logic [XADDR-1:0] or_rd_addr,
    output logic [XLEN-1:0]  or_rd_data,
    output logic             or_retire,
    output logic             or_load_fault
);

    // Counter only needs to reach TIMEOUT-1; the TIMEOUT-th empty cycle faults
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    wb_state_e        state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    load_ctx_t        ctx_q;
    logic [XADDR-1:0] ctx_rd_addr_q;

    logic [2:0]       al_funct3;
    logic [1:0]       al_addr_lo;
    logic [XLEN-1:0]  al_data;
    logic             al_illegal;

    assign o_ready = (state_q == WB_IDLE);

    // One aligner serves both uses: legality of the incoming load while IDLE,
    // data extraction for the captured load while waiting.
    assign al_funct3  = o_ready ? i_funct3  : ctx_q.funct3;
    assign al_addr_lo = o_ready ? i_addr_lo : ctx_q.addr_lo;

    writeback_stage_load_aligner #(
        .DW (XLEN)
    ) u_aligner (
        .funct3_i  (al_funct3),
        .addr_lo_i (al_addr_lo),
        .rdata_i   (i_dmem_rdata),
        .data_o    (al_data),
        .illegal_o (al_illegal)
    );

    // FSM, timeout counter and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= WB_IDLE;
            wait_cnt_q    <= '0;
            ctx_q         <= '0;
            ctx_rd_addr_q <= '0;
            or_wr_en      <= 1'b0;
            or_rd_addr    <= '0;
            or_rd_data    <= '0;
            or_retire     <= 1'b0;
            or_load_fault <= 1'b0;
        end else begin
            or_wr_en      <= 1'b0;
            or_retire     <= 1'b0;
            or_load_fault <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (i_valid) begin
                        if (!i_is_load) begin
                            or_rd_addr <= i_rd_addr;
                            or_rd_data <= i_result;
                            or_wr_en   <= i_rd_we && (i_rd_addr != '0);
                            or_retire  <= 1'b1;
                        end else if (al_illegal) begin
                            or_load_fault <= 1'b1;
                        end else begin
                            ctx_q.rd_we   <= i_rd_we;
                            ctx_q.funct3  <= i_funct3;
                            ctx_q.addr_lo <= i_addr_lo;
                            ctx_rd_addr_q <= i_rd_addr;
                            wait_cnt_q    <= '0;
                            state_q       <= WB_WAIT_MEM;
                        end
                    end
                end
                WB_WAIT_MEM: begin
                    // A response arriving on the last allowed cycle still wins
                    if (i_dmem_rvalid) begin
                        or_rd_addr <= ctx_rd_addr_q;
                        or_rd_data <= al_data;
                        or_wr_en   <= ctx_q.rd_we && (ctx_rd_addr_q != '0);
                        or_retire  <= 1'b1;
                        state_q    <= WB_IDLE;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        or_load_fault <= 1'b1;
                        wait_cnt_q    <= '0;
                        state_q       <= WB_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

endmodule
